inst_fetch: RTL
===============

Name: inst_fetch

Overview:
- Instruction-fetch stage of the MIPS pipeline, directly upstream of the decode field breakdown.
- Owns the PC and issues word requests to instruction memory over a valid/ready request channel with a valid response.
- Presents one registered instruction word plus its PC to decode under a valid/ready handshake.
- Accepts redirects from execute (branch) and decode (jump), discarding any in-flight wrong-path fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded by reset; low 2 bits must be 0.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request this cycle
imem_addr  output  32  byte address of requested word (= pc)
imem_rsp_valid  input  1  response word valid, at most one per accepted request, at least 1 cycle after acceptance
imem_rsp_data  input  32  instruction word
inst_valid  output  1  inst/inst_pc valid to decode
inst_ready  input  1  decode consumes inst this cycle
inst  output  32  registered instruction word
inst_pc  output  32  PC of inst
redirect_valid  input  1  branch taken, from execute
redirect_pc  input  32  branch target; bits [1:0] ignored
jump_valid  input  1  J/JAL decoded, from decode; honoured only while inst_valid=1
jump_index  input  26  jumper field of the held instruction

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset: pc=RESET_PC, state=S_REQ, discard=0, inst=0, inst_pc=0, inst_valid=0. imem_req_valid=0 while reset is high.
- States:
  - S_REQ: imem_req_valid=1, imem_addr=pc. If imem_req_ready=1, go to S_WAIT.
  - S_WAIT: no request. On imem_rsp_valid:
    - discard=1: drop the word, clear discard, go to S_REQ.
    - else: inst<=imem_rsp_data, inst_pc<=pc, inst_valid<=1, pc<=pc+4 (mod 2^32, wraps 0xFFFF_FFFC->0), go to S_HOLD.
  - S_HOLD: inst_valid=1, outputs stable. If inst_ready=1: inst_valid<=0, go to S_REQ.
- At most one request outstanding. Throughput is one instruction per 3 cycles minimum with 1-cycle memory latency; no prefetch.
- Redirect target:
  - redirect_valid has priority over jump_valid.
  - Branch target = {redirect_pc[31:2],2'b00}.
  - Jump target = {inst_pc_plus4[31:28], jump_index, 2'b00}, where inst_pc_plus4 = inst_pc+4.
- Redirect actions (any state), all taking effect in the same cycle:
  - pc<=target and inst_valid<=0. The held instruction is not consumed, regardless of inst_ready.
  - S_REQ with imem_req_ready=0: stay in S_REQ; the next cycle requests the target.
  - S_REQ with imem_req_ready=1: the old address was accepted; go to S_WAIT with discard<=1.
  - S_WAIT, no response this cycle: discard<=1, stay in S_WAIT.
  - S_WAIT, response this cycle: drop the word, go to S_REQ, discard<=0.
  - S_HOLD: go to S_REQ.
- Ignored jumps: jump_valid while inst_valid=0 is ignored. jump_valid together with redirect_valid uses the branch target.
- Reset asserted mid-transaction: state returns to S_REQ with discard=0. The memory must be reset in the same cycle, so no stale response arrives after reset.
- Stability: imem_addr and imem_req_valid hold stable in S_REQ until accepted, unless a redirect changes pc.

Decomposition:
- Shared package mips_pkg holds:
  - state encoding (S_REQ=2'd0, S_WAIT=2'd1, S_HOLD=2'd2)
  - INST_W=32, PC_W=32, JIDX_W=26
  - NOP constant 32'h0000_0000
- One natural sub-module, fetch_pc_sel: combinational next-PC mux (pc+4 / branch / jump, with priority). The FSM and registers stay in inst_fetch.

Test Plan:
- Reset then memory ready with 1-cycle latency returning 0x2000_0001, 0x2000_0002: imem_addr 0x0 then 0x4; inst_valid with inst_pc 0x0, 0x4; inst matches; inst_valid=0 during reset.
- inst_ready low 5 cycles in S_HOLD: inst/inst_pc stable, no imem_req_valid; ready high -> next request at pc+4 the following cycle.
- redirect_valid, redirect_pc=0x0000_0103, in S_WAIT before response: the late response 0xDEAD_BEEF is never presented; next imem_addr=0x100.
- Held inst_pc=0x1000_0008 with jump_valid, jump_index=0x000_0040: next imem_addr=0x1000_0100; no inst_valid for the held word after the jump.
- redirect_valid and jump_valid in the same cycle (redirect_pc=0x200, jump_index=0x3): next imem_addr=0x200.
- RESET_PC=0xFFFF_FFFC, one fetch completes: next imem_addr=0x0000_0000 (wrap). Reset asserted in S_WAIT: next request at RESET_PC, inst_valid=0.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and types for the MIPS fetch/decode slice.
//   STATE_W / S_*     : fetch FSM state encoding
//   INST_W/PC_W/JIDX_W: instruction, PC and jump-index widths
//   NOP               : all-zero instruction word
//   fetch_pkt_t       : registered instruction word plus its PC
//   word_align()      : clears the byte-offset bits of an address
package mips_pkg;

    localparam int unsigned INST_W  = 32;
    localparam int unsigned PC_W    = 32;
    localparam int unsigned JIDX_W  = 26;
    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] S_REQ  = 2'd0;
    localparam logic [STATE_W-1:0] S_WAIT = 2'd1;
    localparam logic [STATE_W-1:0] S_HOLD = 2'd2;

    localparam logic [INST_W-1:0] NOP = 32'h0000_0000;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_pkt_t;

    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// inst_fetch_if: bundles every bus signal of the fetch stage.
//   imem_*     : instruction-memory request (valid/ready) and response (valid)
//   inst*      : registered instruction handed to decode (valid/ready)
//   redirect_* : taken branch from execute
//   jump_*     : J/JAL from decode
// master = fetch stage side, slave = environment (memory, decode, execute).
interface inst_fetch_if;
    import mips_pkg::*;

    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [PC_W-1:0]   imem_addr;
    logic              imem_rsp_valid;
    logic [INST_W-1:0] imem_rsp_data;
    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   inst_pc;
    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;
    logic              jump_valid;
    logic [JIDX_W-1:0] jump_index;

    modport master (
        output imem_req_valid, imem_addr, inst_valid, inst, inst_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
               redirect_valid, redirect_pc, jump_valid, jump_index
    );

    modport slave (
        input  imem_req_valid, imem_addr, inst_valid, inst, inst_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
               redirect_valid, redirect_pc, jump_valid, jump_index
    );

endinterface

// File: rtl/fetch_pc_sel.sv
// fetch_pc_sel: purely combinational next-PC selection.
//   pc_i             : current fetch PC
//   inst_pc_i        : PC of the instruction held for decode
//   redirect_valid_i : taken branch (highest priority)
//   redirect_pc_i    : branch target, byte offset ignored
//   jump_valid_i     : jump already qualified by a held instruction
//   jump_index_i     : 26-bit jump index field
//   seq_pc_o         : pc_i + 4 (wraps)
//   target_pc_o      : selected redirect target
//   redirect_o       : a redirect of either kind is active
module fetch_pc_sel
    import mips_pkg::*;
(
    input  logic [PC_W-1:0]   pc_i,
    input  logic [PC_W-1:0]   inst_pc_i,
    input  logic              redirect_valid_i,
    input  logic [PC_W-1:0]   redirect_pc_i,
    input  logic              jump_valid_i,
    input  logic [JIDX_W-1:0] jump_index_i,
    output logic [PC_W-1:0]   seq_pc_o,
    output logic [PC_W-1:0]   target_pc_o,
    output logic              redirect_o
);

    logic [PC_W-1:0] inst_pc_plus4_c;
    logic [PC_W-1:0] jump_pc_c;
    logic            unused_c;

    assign seq_pc_o        = pc_i + PC_W'(4);
    assign inst_pc_plus4_c = inst_pc_i + PC_W'(4);

    // Jump keeps the 256 MB segment of the instruction after the jump.
    assign jump_pc_c = {inst_pc_plus4_c[PC_W-1:PC_W-4], jump_index_i, 2'b00};

    // Branch wins over a simultaneous jump.
    always_comb begin
        target_pc_o = seq_pc_o;
        if (redirect_valid_i) begin
            target_pc_o = word_align(redirect_pc_i);
        end else if (jump_valid_i) begin
            target_pc_o = jump_pc_c;
        end
    end

    assign redirect_o = redirect_valid_i | jump_valid_i;

    // Low bits of the segment source and the branch byte offset are don't-care.
    assign unused_c = ^{inst_pc_plus4_c[PC_W-5:0], redirect_pc_i[1:0]};

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: MIPS instruction-fetch stage. Owns the PC, issues one word
// request at a time to instruction memory and holds the returned word for
// decode until consumed. Branch/jump redirects replace the PC and squash
// any wrong-path word, including one still in flight.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : inst_fetch_if.master (memory, decode and redirect signals)
module inst_fetch
    import mips_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
)
(
    input  logic         clk,
    input  logic         reset,
    inst_fetch_if.master bus
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               discard_q, discard_d;
    logic               inst_valid_q, inst_valid_d;
    fetch_pkt_t         pkt_q, pkt_d;

    logic [PC_W-1:0]    seq_pc_c;
    logic [PC_W-1:0]    target_pc_c;
    logic               redirect_c;
    logic               jump_ok_c;

    // A jump only means something while its instruction is still held.
    assign jump_ok_c = bus.jump_valid & inst_valid_q;

    fetch_pc_sel u_pc_sel (
        .pc_i             (pc_q),
        .inst_pc_i        (pkt_q.pc),
        .redirect_valid_i (bus.redirect_valid),
        .redirect_pc_i    (bus.redirect_pc),
        .jump_valid_i     (jump_ok_c),
        .jump_index_i     (bus.jump_index),
        .seq_pc_o         (seq_pc_c),
        .target_pc_o      (target_pc_c),
        .redirect_o       (redirect_c)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_REQ;
            pc_q         <= word_align(RESET_PC);
            discard_q    <= 1'b0;
            inst_valid_q <= 1'b0;
            pkt_q        <= '{pc: '0, inst: NOP};
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            discard_q    <= discard_d;
            inst_valid_q <= inst_valid_d;
            pkt_q        <= pkt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        discard_d    = discard_q;
        inst_valid_d = inst_valid_q;
        pkt_d        = pkt_q;

        if (redirect_c) begin
            pc_d         = target_pc_c;
            inst_valid_d = 1'b0;
        end

        case (state_q)
            S_REQ: begin
                if (bus.imem_req_ready) begin
                    state_d = S_WAIT;
                    // The old address was accepted; its word must be dropped.
                    if (redirect_c) begin
                        discard_d = 1'b1;
                    end
                end
            end

            S_WAIT: begin
                if (redirect_c) begin
                    if (bus.imem_rsp_valid) begin
                        state_d   = S_REQ;
                        discard_d = 1'b0;
                    end else begin
                        discard_d = 1'b1;
                    end
                end else if (bus.imem_rsp_valid) begin
                    state_d = S_REQ;
                    if (discard_q) begin
                        discard_d = 1'b0;
                    end else begin
                        pkt_d        = '{pc: pc_q, inst: bus.imem_rsp_data};
                        inst_valid_d = 1'b1;
                        pc_d         = seq_pc_c;
                        state_d      = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                // A redirect squashes the held word even if decode is ready.
                if (redirect_c) begin
                    state_d = S_REQ;
                end else if (bus.inst_ready) begin
                    inst_valid_d = 1'b0;
                    state_d      = S_REQ;
                end
            end

            default: begin
                state_d      = S_REQ;
                discard_d    = 1'b0;
                inst_valid_d = 1'b0;
            end
        endcase
    end

    // Request valid is forced low during reset, so it follows the reset input.
    assign bus.imem_req_valid = (state_q == S_REQ) & ~reset;
    assign bus.imem_addr      = pc_q;
    assign bus.inst_valid     = inst_valid_q;
    assign bus.inst           = pkt_q.inst;
    assign bus.inst_pc        = pkt_q.pc;

endmodule
